// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch/decode handshake bundle for the instruction fetch queue
interface fetch_queue_if #(
  parameter int AW = 2
);
  logic          in_valid;
  logic [31:0]   in_pc;
  logic [31:0]   in_instr;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          out_ready;
  logic          flush;
  logic [AW:0]   count;

  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_instr, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - {PC, instr} queue between fetch and decode; optional same-cycle bypass via FETCH_QUEUE_BYPASS_EN
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic         clk,
  input  logic         reset,
  fetch_queue_if.slave bus
);

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] LP_PTR_ONE = AW'(1);

  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_in_ready;
  logic w_push;
  logic w_pop;
  logic w_bypass;

  // Full/empty come from the occupancy counter only, so pointer wrap needs no care.
  assign w_full     = (r_count == LP_DEPTH);
  assign w_empty    = (r_count == '0);
  // Ready looks at registered state only: a full queue refuses even when the head pops.
  assign w_in_ready = !w_full && !reset;

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue with a consumer waiting: hand the fetched pair straight to decode.
  assign w_bypass = w_empty && bus.in_valid && bus.out_ready && !bus.flush && !reset;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = bus.in_valid && w_in_ready && !w_bypass;
  assign w_pop  = !w_empty && bus.out_ready;

  assign bus.in_ready = w_in_ready;
  assign bus.count    = r_count;

  // Pointer and occupancy update; flush and reset clear everything and win over push/pop.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + LP_ONE;
      else if (w_pop && !w_push) r_count <= r_count - LP_ONE;
    end
  end

  // Entry storage; contents survive flush/reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (w_push && !bus.flush) r_mem[r_wr_ptr] <= {bus.in_pc, bus.in_instr};
  end

  // Head presentation: bypassed pair, stored head, or zeros when nothing is valid.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_pc    = 32'h0000_0000;
    bus.out_instr = 32'h0000_0000;
    if (w_bypass) begin
      bus.out_valid = 1'b1;
      bus.out_pc    = bus.in_pc;
      bus.out_instr = bus.in_instr;
    end else if (!w_empty) begin
      bus.out_valid = 1'b1;
      {bus.out_pc, bus.out_instr} = r_mem[r_rd_ptr];
    end
  end

endmodule
